// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller: state encoding,
// default game parameters and player identifiers.
package pong_pkg;

    // Default game parameters.
    localparam int unsigned WIN_SCORE_DEFAULT   = 7;
    localparam int unsigned SERVE_DELAY_DEFAULT = 120;
    localparam int unsigned SCORE_W_DEFAULT     = 4;

    // Serve countdown width; SERVE_DELAY is truncated to this.
    localparam int unsigned SERVE_CNT_W = 8;

    // Player identifiers, also the encoding of the winner output.
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Game phases. Encodings 6 and 7 are illegal and recover to StIdle.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPause = 3'd3,
        StPoint = 3'd4,
        StOver  = 3'd5
    } game_state_e;

    // Phases in which the ball engine is held in reset.
    function automatic logic holds_ball_rst(input game_state_e st);
        return (st == StIdle) || (st == StPoint) || (st == StOver);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_serve_timer.sv
// Serve delay down-counter. Loaded with SERVE_DELAY before each serve and
// decremented on frame ticks while enabled; done flags the release cycle.
module serve_timer
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    input  logic skip,
    input  logic tick,
    output logic done
);

    localparam logic [SERVE_CNT_W-1:0] LoadVal = SERVE_CNT_W'(SERVE_DELAY);
    localparam logic [SERVE_CNT_W-1:0] One     = SERVE_CNT_W'(1);

    logic [SERVE_CNT_W-1:0] cnt_q, cnt_d;

    // Release on skip, on an already-empty counter (zero delay), or on the
    // tick that would take the count from 1 to 0.
    always_comb begin
        done = enable && (skip || (cnt_q == '0) || (tick && (cnt_q == One)));
    end

    // Next count: load wins; otherwise count down on ticks, never below 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadVal;
        end else if (enable && tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - One;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for the pong datapath: sequences serve/play/pause/
// point/game-over, gates the ball frame tick, re-centres the ball after each
// point and keeps both scores.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = WIN_SCORE_DEFAULT,
    parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEFAULT,
    parameter int unsigned SCORE_W     = SCORE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               btn_start,
    input  logic               btn_serve,
    input  logic               btn_pause,
    input  logic               score_player1,
    input  logic               score_player2,
    output logic               ball_rst,
    output logic               ball_tick,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ScoreOne = SCORE_W'(1);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;
    logic               scorer_q, scorer_d;
    logic               ball_rst_q, ball_rst_d;

    logic               timer_load;
    logic               timer_skip;
    logic               serve_done;
    logic [SCORE_W-1:0] point_score;

    // Increment that sticks at the winning score.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WinScore) ? WinScore : s + ScoreOne;
    endfunction

    serve_timer #(
        .SERVE_DELAY (SERVE_DELAY)
    ) u_serve_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .enable (state_q == StServe),
        .skip   (timer_skip),
        .tick   (refresh_tick),
        .done   (serve_done)
    );

    // Score of whoever won the point just taken.
    assign point_score = (scorer_q == P2) ? score2_q : score1_q;

    // Next-state, score and flag logic; priority is score flag, start,
    // pause, serve, tick countdown.
    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        scorer_d    = scorer_q;
        timer_load  = 1'b0;
        timer_skip  = 1'b0;

        case (state_q)
            StIdle: begin
                if (btn_start) begin
                    score1_d   = '0;
                    score2_d   = '0;
                    timer_load = 1'b1;
                    state_d    = StServe;
                end
            end
            StServe: begin
                timer_skip = btn_serve;
                if (serve_done) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // Player 1 wins a simultaneous double flag.
                if (score_player1) begin
                    score1_d = sat_inc(score1_q);
                    scorer_d = P1;
                    state_d  = StPoint;
                end else if (score_player2) begin
                    score2_d = sat_inc(score2_q);
                    scorer_d = P2;
                    state_d  = StPoint;
                end else if (btn_pause) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (btn_start) begin
                    state_d = StIdle;
                end else if (btn_pause) begin
                    state_d = StPlay;
                end
            end
            StPoint: begin
                if (point_score == WinScore) begin
                    game_over_d = 1'b1;
                    winner_d    = scorer_q;
                    state_d     = StOver;
                end else begin
                    timer_load = 1'b1;
                    state_d    = StServe;
                end
            end
            StOver: begin
                if (btn_start) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    game_over_d = 1'b0;
                    timer_load  = 1'b1;
                    state_d     = StServe;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so ball_rst lines up with the state it belongs to.
        ball_rst_d = holds_ball_rst(state_d);
    end

    // State, score and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            score1_q    <= '0;
            score2_q    <= '0;
            game_over_q <= 1'b0;
            winner_q    <= P1;
            scorer_q    <= P1;
            ball_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            scorer_q    <= scorer_d;
            ball_rst_q  <= ball_rst_d;
        end
    end

    // Frame tick passes straight through only while playing.
    assign ball_tick = refresh_tick & (state_q == StPlay);
    assign ball_rst  = ball_rst_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios with literal
// expectations, then randomized play checked every cycle against a
// behavioural game model.
module tb_pong_game_ctrl;

    localparam int WIN = 3;
    localparam int DLY = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_serve = 1'b0;
    logic       btn_pause = 1'b0;
    logic       score_player1 = 1'b0;
    logic       score_player2 = 1'b0;
    logic       ball_rst;
    logic       ball_tick;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       winner;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    // Behavioural game model: phase number, scores, serve ticks left,
    // game-over flag, winner and last scorer.
    int m_state, m_s1, m_s2, m_left, m_go, m_win, m_who;

    pong_game_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_DELAY (DLY),
        .SCORE_W     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .refresh_tick  (refresh_tick),
        .btn_start     (btn_start),
        .btn_serve     (btn_serve),
        .btn_pause     (btn_pause),
        .score_player1 (score_player1),
        .score_player2 (score_player2),
        .ball_rst      (ball_rst),
        .ball_tick     (ball_tick),
        .score1        (score1),
        .score2        (score2),
        .game_over     (game_over),
        .winner        (winner),
        .state_o       (state_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_s1 = 0; m_s2 = 0; m_left = 0; m_go = 0; m_win = 0; m_who = 0;
    endtask

    // One clock of game rules applied to the inputs present at that edge.
    task automatic model_step();
        int pts;
        case (m_state)
            0: if (btn_start) begin
                m_s1 = 0; m_s2 = 0; m_left = DLY; m_state = 1;
            end
            1: begin
                if (btn_serve || m_left == 0 || (refresh_tick && m_left == 1)) m_state = 2;
                else if (refresh_tick) m_left = m_left - 1;
            end
            2: begin
                if (score_player1) begin
                    m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; m_who = 0; m_state = 4;
                end else if (score_player2) begin
                    m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; m_who = 1; m_state = 4;
                end else if (btn_pause) m_state = 3;
            end
            3: begin
                if (btn_start) m_state = 0;
                else if (btn_pause) m_state = 2;
            end
            4: begin
                pts = (m_who == 0) ? m_s1 : m_s2;
                if (pts == WIN) begin
                    m_go = 1; m_win = m_who; m_state = 5;
                end else begin
                    m_left = DLY; m_state = 1;
                end
            end
            5: if (btn_start) begin
                m_s1 = 0; m_s2 = 0; m_go = 0; m_left = DLY; m_state = 1;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare();
        int exp_rst;
        exp_rst = (m_state == 0 || m_state == 4 || m_state == 5) ? 1 : 0;
        chk("state_o", int'(state_o), m_state);
        chk("ball_rst", int'(ball_rst), exp_rst);
        chk("ball_tick", int'(ball_tick), (m_state == 2 && refresh_tick) ? 1 : 0);
        chk("score1", int'(score1), m_s1);
        chk("score2", int'(score2), m_s2);
        chk("game_over", int'(game_over), m_go);
        if (m_go != 0) chk("winner", int'(winner), m_win);
    endtask

    // Per-cycle comparison, mid low phase after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (checking) compare();
    end

    task automatic apply(input bit st, input bit sv, input bit pa, input bit tk,
                         input bit p1, input bit p2);
        @(negedge clk);
        btn_start = st; btn_serve = sv; btn_pause = pa;
        refresh_tick = tk; score_player1 = p1; score_player2 = p2;
        #1;
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic cyc(input bit st, input bit sv, input bit pa, input bit tk,
                       input bit p1, input bit p2);
        apply(st, sv, pa, tk, p1, p2);
        clk_step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_ball_rst"}, int'(ball_rst), 1);
        chk({tag, "_ball_tick"}, int'(ball_tick), 0);
        chk({tag, "_score1"}, int'(score1), 0);
        chk({tag, "_score2"}, int'(score2), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
        chk({tag, "_winner"}, int'(winner), 0);
    endtask

    initial begin
        bit st, sv, pa, tk, p1, p2;
        model_reset();
        #1 reset = 1'b0;
        model_reset();
        checking = 1'b1;
        #1 chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Start, then serve delay of 3 ticks.
        cyc(1, 0, 0, 0, 0, 0);
        chk("start_to_serve", int'(state_o), 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("serve_after_2_ticks", int'(state_o), 1);
        apply(0, 0, 0, 1, 0, 0);
        chk("tick3_gated", int'(ball_tick), 0);
        clk_step();
        chk("play_on_tick3", int'(state_o), 2);
        apply(0, 0, 0, 1, 0, 0);
        chk("tick4_passes", int'(ball_tick), 1);
        clk_step();

        // Player 2 point; flag held into SERVE adds nothing.
        cyc(0, 0, 0, 0, 0, 1);
        chk("p2_score", int'(score2), 1);
        chk("p2_ball_rst", int'(ball_rst), 1);
        chk("p2_point", int'(state_o), 4);
        cyc(0, 0, 0, 0, 0, 1);
        chk("p2_serve", int'(state_o), 1);
        chk("p2_ball_rst_drop", int'(ball_rst), 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("p2_no_double", int'(score2), 1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("serve_skip", int'(state_o), 2);

        // Both flags together: player 1 only.
        cyc(0, 0, 0, 0, 1, 1);
        chk("both_s1", int'(score1), 1);
        chk("both_s2", int'(score2), 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);

        // Pause blocks ticks, resume lets the next one through.
        cyc(0, 0, 1, 0, 0, 0);
        chk("paused", int'(state_o), 3);
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 0, 1, 0, 0);
            chk("pause_tick", int'(ball_tick), 0);
            clk_step();
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("resumed", int'(state_o), 2);
        apply(0, 0, 0, 1, 0, 0);
        chk("resume_tick", int'(ball_tick), 1);
        clk_step();

        // Player 1 reaches 3 and wins.
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("win_point", int'(state_o), 4);
        cyc(0, 0, 0, 0, 0, 0);
        chk("over_state", int'(state_o), 5);
        chk("over_flag", int'(game_over), 1);
        chk("over_winner", int'(winner), 0);
        chk("over_score1", int'(score1), 3);
        chk("model_over_s1", m_s1, 3);
        cyc(0, 0, 0, 1, 1, 1);
        chk("over_frozen_state", int'(state_o), 5);
        chk("over_frozen_s1", int'(score1), 3);
        chk("over_frozen_s2", int'(score2), 1);

        // New game, reach score1=2 in SERVE, then async reset.
        cyc(1, 0, 0, 0, 0, 0);
        chk("restart_s1", int'(score1), 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pre_reset_s1", int'(score1), 2);
        chk("pre_reset_state", int'(state_o), 1);
        #1 reset = 1'b0;
        model_reset();
        #1 chk_reset_outputs("async");
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk) reset = 1'b1;

        // Randomized play against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 799) == 0) begin
                #1 reset = 1'b0;
                model_reset();
                cyc(0, 0, 0, 0, 0, 0);
                @(negedge clk) reset = 1'b1;
            end
            st = (m_state == 0 || m_state == 3 || m_state == 5) && ($urandom_range(0, 5) == 0);
            sv = ($urandom_range(0, 15) == 0);
            pa = ($urandom_range(0, 9) == 0);
            tk = ($urandom_range(0, 2) == 0);
            p1 = ($urandom_range(0, 11) == 0);
            p2 = ($urandom_range(0, 11) == 0);
            cyc(st, sv, pa, tk, p1, p2);
        end

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the pong datapath. It sequences the ball engine through idle, serve, play, pause, point and game-over phases. It gates the ball's frame tick, pulses the ball's reset to re-centre it after each point, and keeps both players' scores. It sits between the frame-tick generator and the ball engine; its score and state outputs feed the score display and the renderer.

## Interface
- `WIN_SCORE`, 7: points needed to win; range 1..15.
- `SERVE_DELAY`, 120: frame ticks to wait in SERVE before the ball is released (2 s at 60 Hz).
- `SCORE_W`, 4: score counter width; must hold `WIN_SCORE`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `refresh_tick` in 1: one-cycle frame pulse.
- `btn_start` in 1: debounced one-cycle pulse; starts or restarts a game.
- `btn_serve` in 1: debounced one-cycle pulse; skips the remaining serve delay.
- `btn_pause` in 1: debounced one-cycle pulse; toggles between PLAY and PAUSE.
- `score_player1`, `score_player2` in 1 each: sticky point flags from the ball engine. They clear only when the ball engine is reset.
- `ball_rst` out 1: active-high reset to the ball engine.
- `ball_tick` out 1: gated frame tick to the ball engine.
- `score1`, `score2` out `SCORE_W` each: player scores.
- `game_over` out 1: high while in OVER.
- `winner` out 1: 0 = player 1 won, 1 = player 2 won. Valid only while `game_over` is high.
- `state_o` out 3: current state encoding.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, OVER=5. Encodings 6 and 7 go to IDLE on the next clock.
- IDLE: `ball_rst`=1 and scores are held.
  - `btn_start` clears both scores, loads the serve counter with `SERVE_DELAY`, and moves to SERVE.
- SERVE: `ball_rst`=0 and the ball is frozen.
  - Each `refresh_tick` decrements the counter.
  - The move to PLAY happens on the tick that would take the counter from 1 to 0.
  - `btn_serve` moves to PLAY immediately.
  - `SERVE_DELAY`=0 means the move to PLAY happens on the next clock.
- PLAY: `ball_tick` = `refresh_tick`.
  - A score flag seen high moves to POINT. At that transition the controller increments the matching score and sets `ball_rst`=1.
  - If both flags are high together, player 1 gets the point and player 2 gets nothing.
  - `btn_pause` moves to PAUSE. A score flag takes priority over `btn_pause` in the same cycle.
- PAUSE: the ball is frozen and scores are held.
  - `btn_pause` returns to PLAY.
  - `btn_start` aborts the game to IDLE.
- POINT: lasts exactly one cycle, with `ball_rst`=1; the ball engine re-centres and clears its flags.
  - If the incremented score equals `WIN_SCORE`: go to OVER, set `game_over`=1, set `winner`.
  - Otherwise: load the serve counter and go to SERVE.
- OVER: `ball_rst`=1 and scores are frozen.
  - `btn_start` clears scores and `game_over` and moves to SERVE, as from IDLE.
- Outside PLAY, `ball_tick` = 0.
- Score flags are ignored outside PLAY.
- Score arithmetic: unsigned, width `SCORE_W`. The counters saturate at `WIN_SCORE` and never wrap.
- Serve counter: 8 bits, unsigned. It never decrements below 0.

## Timing
- Reset values: `state_o`=IDLE, `ball_rst`=1, `ball_tick`=0, `score1`=`score2`=0, `game_over`=0, `winner`=0, serve counter 0.
- A `reset` assertion in mid-game takes effect asynchronously. All outputs go to their reset values immediately.
- All outputs are registered except `ball_tick`, which is `refresh_tick` AND'ed with the registered PLAY decode (zero latency).
- Button, flag and tick inputs are sampled on the `clk` rising edge.
- Score latency: a flag sampled high at edge N gives an updated score and `ball_rst`=1 after edge N, and `state_o`=POINT after edge N.
  - `ball_rst` returns to 0 after edge N+1, when the state moves to SERVE.
- `ball_rst` is high for exactly one cycle per point. This is enough for the ball engine's asynchronous reset.
- No `ball_tick` is issued during the POINT cycle or during the serve delay.
- Simultaneous events, highest priority first:
  - `reset`
  - score flag
  - `btn_start`
  - `btn_pause`
  - `btn_serve`
  - `refresh_tick` countdown

## Structure
- Shared package `pong_pkg` holds:
  - the state encoding constants and the state typedef
  - the `WIN_SCORE` and `SERVE_DELAY` defaults
  - the player-id constants P1=0, P2=1
- One natural sub-module, `serve_timer`: a loadable down-counter on `refresh_tick` with a `load`/`skip` input and a `done` output.
- The FSM, score counters and output registers live in `pong_game_ctrl`.

## Test plan
- Reset released, then `btn_start`: `state_o` steps 0→1. With `SERVE_DELAY`=3, PLAY is entered on the 3rd `refresh_tick`. `ball_tick` first pulses on the 4th tick.
- In PLAY, hold `score_player2`=1 at edge N: `score2` 0→1 after N, `ball_rst` high exactly 1 cycle, then SERVE. The same flag still high during SERVE does not add a point.
- `WIN_SCORE`=3, drive three player-1 points: after the third POINT cycle `state_o`=5, `game_over`=1, `winner`=0, `score1`=3. Further flags leave it unchanged.
- Both score flags high in the same cycle: `score1` +1, `score2` unchanged.
- `btn_pause` in PLAY: 10 `refresh_tick` pulses give `ball_tick`=0 throughout. A second `btn_pause` resumes PLAY, and the next tick passes through.
- `reset` driven low mid-SERVE with `score1`=2: all outputs go to reset values asynchronously, before the next `clk` edge.
